// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared definitions for the iterative multiply/divide control slice.
//   - state_e      : sequencer state encoding (ST_IDLE, ST_LOAD, ST_RUN, ST_FINISH)
//   - OP_W         : operand width
//   - *_ITERS_DEF  : default datapath step counts
//   - op_req_t     : operation captured at a start pulse
package multdiv_pkg;

   localparam int OP_W           = 32;
   localparam int MULT_ITERS_DEF = 16;   // radix-4 Booth: 2 bits per step
   localparam int DIV_ITERS_DEF  = 32;   // restoring divide: 1 bit per step

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_RUN    = 2'd2,
      ST_FINISH = 2'd3
   } state_e;

   typedef struct packed {
      logic            div;   // 1 = divide, 0 = multiply
      logic            dbz;   // divide with zero divisor
      logic [OP_W-1:0] a;
      logic [OP_W-1:0] b;
   } op_req_t;

endpackage

// File: rtl/multdiv_iter_counter.sv
// multdiv_iter_counter: CNT_W-bit synchronous up-counter with terminal-count compare.
//   clk    in  : rising-edge clock
//   clr    in  : synchronous clear (priority over en)
//   en     in  : increment enable
//   tc_val in  : terminal-count value to compare against
//   count  out : current count
//   tc     out : count == tc_val
module multdiv_iter_counter #(
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] tc_val,
   output logic [CNT_W-1:0] count,
   output logic             tc
);

   always_ff @(posedge clk) begin
      if (clr)     count <= '0;
      else if (en) count <= count + 1'b1;
   end

   assign tc = (count == tc_val);

endmodule

// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: control stage for the iterative 32-bit multiplier/divider.
//   clk, clr           : clock, synchronous active-high reset
//   ctrl_MULT/ctrl_DIV : start pulses (both high = multiply)
//   data_operandA/B    : operands, sampled only in a start cycle
//   dp_overflow        : datapath overflow, meaningful in FINISH
//   opA_q/opB_q/op_div : latched operation to the datapath
//   dp_load/dp_step    : datapath initialise / iterate strobes
//   busy               : operation in flight
//   data_resultRDY     : one-cycle result-valid pulse
//   data_exception     : overflow or divide-by-zero, qualified by data_resultRDY
module multdiv_sequencer
   import multdiv_pkg::*;
#(
   parameter int MULT_ITERS = MULT_ITERS_DEF,
   parameter int DIV_ITERS  = DIV_ITERS_DEF,
   parameter int CNT_W      = 6
) (
   input  logic            clk,
   input  logic            clr,
   input  logic            ctrl_MULT,
   input  logic            ctrl_DIV,
   input  logic [OP_W-1:0] data_operandA,
   input  logic [OP_W-1:0] data_operandB,
   input  logic            dp_overflow,
   output logic [OP_W-1:0] opA_q,
   output logic [OP_W-1:0] opB_q,
   output logic            op_div,
   output logic            dp_load,
   output logic            dp_step,
   output logic            busy,
   output logic            data_resultRDY,
   output logic            data_exception
);

   state_e           state, state_nx;
   op_req_t          req_q, start_req;
   logic             start;
   logic [CNT_W-1:0] iter_cnt, tc_val;
   logic             iter_tc;

   assign start = ctrl_MULT | ctrl_DIV;

   // Multiply wins when both pulses arrive, so a zero B is only a fault for a pure divide.
   always_comb begin
      start_req.div = ~ctrl_MULT;
      start_req.dbz = ~ctrl_MULT & (data_operandB == '0);
      start_req.a   = data_operandA;
      start_req.b   = data_operandB;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state <= ST_IDLE;
         req_q <= '0;
      end else begin
         state <= state_nx;
         if (start) req_q <= start_req;
      end
   end

   // A start in any state aborts whatever is running; RUN therefore never reaches
   // FINISH in a cycle that also carries a start.
   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE:   state_nx = ST_IDLE;
         ST_LOAD:   state_nx = ST_RUN;
         ST_RUN:    if (iter_tc) state_nx = ST_FINISH;
         ST_FINISH: state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
      if (start) state_nx = start_req.dbz ? ST_FINISH : ST_LOAD;
   end

   assign tc_val = req_q.div ? CNT_W'(DIV_ITERS - 1) : CNT_W'(MULT_ITERS - 1);

   multdiv_iter_counter #(.CNT_W(CNT_W)) u_iter_counter (
      .clk    (clk),
      .clr    (clr | start),
      .en     (state == ST_RUN),
      .tc_val (tc_val),
      .count  (iter_cnt),
      .tc     (iter_tc)
   );

   // Counter must never run past its terminal count while stepping.
   a_cnt_range: assert property (@(posedge clk) disable iff (clr)
      (state == ST_RUN) |-> (iter_cnt <= tc_val));

   assign opA_q          = req_q.a;
   assign opB_q          = req_q.b;
   assign op_div         = req_q.div;
   assign dp_load        = (state == ST_LOAD);
   assign dp_step        = (state == ST_RUN);
   assign busy           = (state != ST_IDLE);
   assign data_resultRDY = (state == ST_FINISH);
   // Overflow is passed straight through in FINISH; a divide only faults on zero divisor.
   assign data_exception = (state == ST_FINISH) &
                           (req_q.dbz | (~req_q.div & dp_overflow));

endmodule

// File: tb/tb_multdiv_sequencer.sv
module tb_multdiv_sequencer;

   logic        clk = 0, clr = 1, ctrl_MULT = 0, ctrl_DIV = 0, dp_overflow = 0;
   logic [31:0] data_operandA = 0, data_operandB = 0;
   logic [31:0] opA_q, opB_q;
   logic        op_div, dp_load, dp_step, busy, data_resultRDY, data_exception;

   int tests = 0, fails = 0;
   logic chk_en = 0;

   multdiv_sequencer dut (
      .clk(clk), .clr(clr), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
      .data_operandA(data_operandA), .data_operandB(data_operandB),
      .dp_overflow(dp_overflow), .opA_q(opA_q), .opB_q(opB_q), .op_div(op_div),
      .dp_load(dp_load), .dp_step(dp_step), .busy(busy),
      .data_resultRDY(data_resultRDY), .data_exception(data_exception)
   );

   always #5 clk = ~clk;

   // ---- behavioural model: cycle index since the last start ----
   logic        m_act = 0, m_div = 0, m_dbz = 0;
   int          m_rel = 0;
   logic [31:0] m_a = 0, m_b = 0;

   function automatic int m_iters(input logic div);
      return div ? 32 : 16;
   endfunction

   function automatic int m_end(input logic div, input logic dbz);
      return dbz ? 1 : m_iters(div) + 2;
   endfunction

   always @(posedge clk) begin
      if (clr) begin
         m_act <= 0; m_rel <= 0; m_div <= 0; m_dbz <= 0; m_a <= 0; m_b <= 0;
      end else if (ctrl_MULT || ctrl_DIV) begin
         m_act <= 1; m_rel <= 1;
         m_div <= !ctrl_MULT;
         m_dbz <= !ctrl_MULT && (data_operandB == 0);
         m_a   <= data_operandA; m_b <= data_operandB;
      end else if (m_act) begin
         if (m_rel >= m_end(m_div, m_dbz)) m_act <= 0;
         m_rel <= m_rel + 1;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---- per-cycle compare ----
   always @(negedge clk) begin
      if (chk_en) begin
         logic e_load, e_step, e_rdy, e_exc;
         logic [70:0] got, exp;
         e_load = m_act && !m_dbz && m_rel == 1;
         e_step = m_act && !m_dbz && m_rel >= 2 && m_rel <= m_iters(m_div) + 1;
         e_rdy  = m_act && m_rel == m_end(m_div, m_dbz);
         e_exc  = e_rdy && (m_dbz || (!m_div && dp_overflow));
         got = {opA_q, opB_q, op_div, dp_load, dp_step, busy, data_resultRDY, data_exception};
         exp = {m_a, m_b, m_div, e_load, e_step, m_act, e_rdy, e_exc};
         tests++;
         if (got !== exp) begin
            fails++;
            $display("FAIL cycle_cmp: got %h expected %h (t=%0t)", got, exp, $time);
         end
      end
   end

   // ---- stimulus helpers ----
   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
      ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b;
      next_cycle();
      ctrl_MULT = 0; ctrl_DIV = 0;
      data_operandA = $urandom; data_operandB = $urandom;   // must be ignored
   endtask

   // Called while in cycle k0 after the start edge; finds the resultRDY cycle.
   task automatic wait_rdy(input string nm, input int k0, input int exp_k,
                           input int exp_steps, input logic exp_exc);
      int k = k0, steps = 0;
      bit found = 0;
      while (k <= 60 && !found) begin
         @(negedge clk);
         if (data_resultRDY) found = 1;
         else begin
            if (dp_step) steps++;
            next_cycle(); k++;
         end
      end
      chk({nm, "_rdy_cycle"}, found ? k : -1, exp_k);
      chk({nm, "_steps"}, steps, exp_steps);
      chk({nm, "_exc"}, data_exception, exp_exc);
      next_cycle();
   endtask

   initial begin
      next_cycle(); next_cycle();
      clr = 0; chk_en = 1;
      @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_opA", opA_q, 0);
      next_cycle();

      // multiply 7 x 6
      start_op(1, 0, 7, 6);
      @(negedge clk);
      chk("mul_load_c1", {dp_load, dp_step, busy}, 3'b101);
      next_cycle();
      wait_rdy("mul7x6", 2, 18, 16, 0);
      chk("mul_opA", opA_q, 7);
      chk("mul_opB", opB_q, 6);

      // divide 100 / 7
      start_op(0, 1, 100, 7);
      wait_rdy("div100_7", 1, 34, 32, 0);

      // multiply with datapath overflow
      dp_overflow = 1;
      start_op(1, 0, 32'h8000_0000, 32'h4);
      wait_rdy("mul_ovf", 1, 18, 16, 1);
      dp_overflow = 0;

      // divide by zero
      start_op(0, 1, 5, 0);
      wait_rdy("div_by0", 1, 1, 0, 1);
      @(negedge clk);
      chk("div_by0_busy_c2", busy, 0);
      next_cycle();

      // restart: DIV 9/3 arrives in the fifth RUN cycle of a multiply
      start_op(1, 0, 11, 13);
      repeat (5) next_cycle();
      @(negedge clk);
      chk("restart_in_run", {dp_step, busy}, 2'b11);
      start_op(0, 1, 9, 3);
      @(negedge clk);
      chk("restart_div_load", {op_div, dp_load, opA_q, opB_q}, {2'b11, 32'd9, 32'd3});
      next_cycle();
      wait_rdy("restart_div", 2, 34, 32, 0);

      // simultaneous start with B = 0 is a multiply
      start_op(1, 1, 21, 0);
      @(negedge clk);
      chk("both_op_div", op_div, 0);
      next_cycle();
      wait_rdy("both_b0", 2, 18, 16, 0);

      // reset mid-RUN, with a start pulse in the first clr cycle
      start_op(1, 0, 3, 4);
      repeat (4) next_cycle();
      clr = 1; ctrl_MULT = 1; data_operandA = 55; data_operandB = 66;
      next_cycle();
      ctrl_MULT = 0;
      next_cycle();
      clr = 0;
      @(negedge clk);
      chk("clr_outputs", {opA_q, opB_q, op_div, dp_load, dp_step, busy, data_resultRDY, data_exception}, 0);
      repeat (25) next_cycle();   // per-cycle compare flags any stray resultRDY

      // recovery after reset
      start_op(1, 0, 2, 2);
      wait_rdy("post_clr_mul", 1, 18, 16, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
